// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Iterative 32-bit multiply/divide unit owning HI/LO.
//               MULT/MULTU use shift-add, DIV/DIVU use restoring division,
//               one bit per cycle. Optional div0 flag: MD_DIV0_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
`ifdef MD_DIV0_FLAG_EN
    ,
    output logic        div0
`endif
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_PREP = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;
    localparam logic [1:0] c_ST_FIX  = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [4:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_acc;
    logic [31:0] r_q;
    logic [31:0] r_m;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_start_ok;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [32:0] w_sum;
    logic [32:0] w_rsh;
    logic        w_ge;
    logic [31:0] w_rdif;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_start_ok = (r_state == c_ST_IDLE) && start && !flush;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start && !flush) w_state_nxt = c_ST_PREP;
            c_ST_PREP: w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (r_cnt == 5'd0) w_state_nxt = c_ST_FIX;
            c_ST_FIX:  w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
        if (flush && (r_state != c_ST_IDLE)) w_state_nxt = c_ST_IDLE;
    end

    // Magnitudes; 0x80000000 maps onto itself, which is correct as unsigned.
    assign w_a_neg = r_op[0] && r_a[31];
    assign w_b_neg = r_op[0] && r_b[31];
    assign w_a_abs = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_b_abs = w_b_neg ? (32'd0 - r_b) : r_b;

    assign w_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : 33'd0);

    // The bit shifted out of R is kept so divisors above 2^31 stay exact.
    assign w_rsh  = {r_acc, r_q[31]};
    assign w_ge   = (w_rsh >= {1'b0, r_m});
    assign w_rdif = w_rsh[31:0] - r_m;

    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = (r_op[0] && (r_a[31] ^ r_b[31])) ? (64'd0 - w_prod) : w_prod;
    assign w_quo_fix  = (r_op[0] && (r_a[31] ^ r_b[31])) ? (32'd0 - r_q) : r_q;
    assign w_rem_fix  = (r_op[0] && r_a[31]) ? (32'd0 - r_acc) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 5'd0;
            r_op    <= 2'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_acc   <= 32'd0;
            r_q     <= 32'd0;
            r_m     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (w_start_ok) begin
                        r_op <= op;
                        r_a  <= rs;
                        r_b  <= rt;
                    end
                end
                c_ST_PREP: begin
                    r_cnt <= 5'd31;
                    r_acc <= 32'd0;
                    if (r_op[1]) begin
                        r_q <= w_a_abs;
                        r_m <= w_b_abs;
                    end else begin
                        r_q <= w_b_abs;
                        r_m <= w_a_abs;
                    end
                end
                c_ST_RUN: begin
                    if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
                    if (r_op[1]) begin
                        r_acc <= w_ge ? w_rdif : w_rsh[31:0];
                        r_q   <= {r_q[30:0], w_ge};
                    end else begin
                        r_acc <= w_sum[32:1];
                        r_q   <= {w_sum[0], r_q[31:1]};
                    end
                end
                c_ST_FIX: begin
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (r_op[1]) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[63:32];
                            r_lo <= w_prod_fix[31:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MD_DIV0_FLAG_EN
    logic r_div0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div0 <= 1'b0;
        end else if (w_start_ok) begin
            r_div0 <= 1'b0;
        end else if ((r_state == c_ST_FIX) && !flush && r_op[1] && (r_b == 32'd0)) begin
            r_div0 <= 1'b1;
        end
    end

    assign div0 = r_div0;
`endif

    assign busy = (r_state != c_ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire
